row_line_buffer: RTL and testbench
==================================

// Module: row_line_buffer
// PURPOSE
//  Line-buffer stage directly upstream of the row-end signal generator and the parallel kernel units.
//  Accepts NO_PARALLEL_UNITS pixels per beat in raster order and stores KER_SIZE-1 previous rows.
//  Emits one vertical KER_SIZE-tap column per unit per beat.
//  Drives the stall and clrbuffer strobes that keep the row-end column count aligned with its data.
// PARAMETERS
//  IM_LEN            16'd520  pixels per image row; must be divisible by NO_PARALLEL_UNITS
//  IM_ROWS           16'd520  rows per frame
//  KER_SIZE          3        kernel height; number of output taps (>=2)
//  NO_PARALLEL_UNITS 4        pixels per beat
//  PIX_W             8        bits per pixel
//  Derived: WORDS = IM_LEN/NO_PARALLEL_UNITS (beats per row); BW = NO_PARALLEL_UNITS*PIX_W
// PORTS
//  clk        in   1              clock, all state on rising edge
//  res        in   1              reset, asynchronous, active-low
//  in_valid   in   1              input beat valid
//  in_ready   out  1              input beat accepted when in_valid & in_ready
//  in_pix     in   BW             unit u pixel at [u*PIX_W +: PIX_W]
//  out_valid  out  1              col_data valid
//  out_ready  in   1              downstream accepts beat
//  col_data   out  KER_SIZE*BW    tap k at [k*BW +: BW]: k=0 current row, k=j row r-j, same column word
//  out_last   out  1              qualifies the final beat of a frame
//  stall      out  1              to row-end generator: 1 = no beat consumed this cycle
//  clrbuffer  out  1              to row-end generator: 1-cycle frame-boundary clear
// BEHAVIOUR
//  - Reset (res=0, async): col_cnt=0, row_cnt=0, out_valid=0, out_last=0, clrbuffer=0, col_data=0.
//    Row-buffer RAM is not reset. Reset mid-frame abandons the frame; the next accepted beat is row 0, col 0.
//  - Handshake: in_ready = out_ready | ~out_valid (single output register, no bubble).
//    accept = in_valid & in_ready. A beat held under backpressure keeps col_data and out_last stable.
//  - Storage: KER_SIZE-1 buffers, each WORDS x BW, addressed by col_cnt. On accept:
//    buf[0][col] <= in_pix; buf[j][col] <= old buf[j-1][col] (read-before-write, same edge).
//  - Output register (latency 1 beat): col_data tap0 <= in_pix; tap j <= old buf[j-1][col].
//  - Counters advance on accept only. col_cnt wraps WORDS-1 -> 0 and then increments row_cnt.
//    row_cnt wraps IM_ROWS-1 -> 0 at the last column.
//  - Priming: out_valid <= accept & (row_cnt >= KER_SIZE-1).
//    Rows 0..KER_SIZE-2 are absorbed into the buffers, never emitted.
//    When a priming beat is accepted and out_ready=1, out_valid drops to 0.
//  - out_last <= accept & (row_cnt==IM_ROWS-1) & (col_cnt==WORDS-1).
//  - stall = ~(out_valid & out_ready), combinational. It is 1 during reset, priming and backpressure,
//    so the downstream column count advances exactly once per consumed beat.
//  - clrbuffer: registered; 1 for exactly one cycle after the cycle where out_valid & out_ready & out_last.
//    0 otherwise.
//  - Simultaneous in-accept and out-consume in the same cycle is full throughput: one beat per clock.
// CONFIGURATION
//  LB_TOP_PAD_EN defined:
//    - No priming suppression: out_valid <= accept for every row.
//    - Tap j is forced to 0 while row_cnt < j (zero padding at the frame top).
//    - A per-tap valid mask enforces this; the mask resets to 0, and it re-clears when row_cnt wraps to 0.
//    - Output count per frame = IM_ROWS*WORDS.
//  LB_TOP_PAD_EN undefined:
//    - Priming as above. Output count per frame = (IM_ROWS-KER_SIZE+1)*WORDS. No mask logic.
// TESTING  (IM_LEN=8, NO_PARALLEL_UNITS=4 -> WORDS=2, IM_ROWS=4, KER_SIZE=3, PIX_W=8)
//  1 Stream 8 beats, beat n = {4{8'(n)}}, out_ready=1 -> no out_valid for beats 0..3.
//    Beat 4 gives tap0=04, tap1=02, tap2=00 one cycle later. Beat 5 gives 05/03/01.
//  2 Continue to beat 7 -> out_last=1 with beat 7 (07/05/03).
//    clrbuffer=1 for exactly the next cycle. Second frame primes again (no output for its rows 0-1).
//  3 Hold out_ready=0 for 3 cycles at beat 4 -> col_data stable, in_ready=0, stall=1.
//    Beats 5.. are not lost and resume in order.
//  4 Deassert in_valid every other cycle -> stall=1 on idle cycles.
//    Exactly WORDS stall=0 cycles per emitted row.
//  5 Assert res=0 mid-frame after beat 5 -> out_valid=0, stall=1 immediately.
//    Next frame fully re-primes (first output on its 5th beat).
//  6 LB_TOP_PAD_EN: beat 0 -> out_valid=1 with 00/00/00. Beat 2 -> 02/00/00.
//    Beat 4 -> 04/02/00. Frame yields 8 outputs.

Source files
------------

// File: rtl/row_line_buffer_if.sv
// Stream bundle for row_line_buffer: raster pixel beats in, KER_SIZE-tap column beats out,
// plus the stall/clrbuffer strobes for the row-end generator.
interface row_line_buffer_if #(
  parameter int BW       = 32,
  parameter int KER_SIZE = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [BW-1:0]          in_pix;
  logic                   out_valid;
  logic                   out_ready;
  logic [KER_SIZE*BW-1:0] col_data;
  logic                   out_last;
  logic                   stall;
  logic                   clrbuffer;

  // Both sides use valid/ready: a beat moves on a rising edge where valid & ready are both 1.
  // The sender holds its data stable while valid=1 and ready=0.
  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, col_data, out_last, stall, clrbuffer
  );

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, col_data, out_last, stall, clrbuffer
  );
endinterface

// File: rtl/row_line_buffer.sv
// Line buffer: keeps KER_SIZE-1 previous rows and emits one vertical column per unit per beat.
// Optional macro LB_TOP_PAD_EN: emit every row, zero-padding taps that fall above the frame top.
module row_line_buffer #(
  parameter logic [15:0] IM_LEN            = 16'd520,
  parameter logic [15:0] IM_ROWS           = 16'd520,
  parameter int          KER_SIZE          = 3,
  parameter int          NO_PARALLEL_UNITS = 4,
  parameter int          PIX_W             = 8
) (
  input  logic clk,
  input  logic res,
  row_line_buffer_if.slave lb
);
  localparam int WORDS = int'(IM_LEN) / NO_PARALLEL_UNITS;
  localparam int BW    = NO_PARALLEL_UNITS * PIX_W;
  localparam int NBUF  = KER_SIZE - 1;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0]          col_cnt;
  logic [15:0]            row_cnt;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   clrbuffer_q;
  logic [KER_SIZE*BW-1:0] col_data_q;
  logic [KER_SIZE*BW-1:0] next_col;
  logic [BW-1:0]          row_buf [NBUF][WORDS];
  logic                   in_ready;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   emit;

  assign in_ready = lb.out_ready | ~out_valid_q;
  assign accept   = lb.in_valid & in_ready;
  assign col_last = (col_cnt == CW'(WORDS - 1));
  assign row_last = (row_cnt == IM_ROWS - 16'd1);

`ifdef LB_TOP_PAD_EN
  // tap_mask[j-1] says tap j points at a real row of this frame (row_cnt >= j).
  logic [NBUF-1:0] tap_mask;

  assign emit = 1'b1;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tap_mask <= '0;
    end else if (accept && col_last) begin
      if (row_last) tap_mask <= '0;
      else          tap_mask <= (tap_mask << 1) | NBUF'(1);
    end
  end

  always_comb begin
    next_col          = '0;
    next_col[BW-1:0]  = lb.in_pix;
    for (int j = 1; j < KER_SIZE; j++) begin
      next_col[j*BW +: BW] = tap_mask[j-1] ? row_buf[j-1][col_cnt] : '0;
    end
  end
`else
  // The first KER_SIZE-1 rows only fill the buffers.
  assign emit = (row_cnt >= 16'(KER_SIZE - 1));

  always_comb begin
    next_col          = '0;
    next_col[BW-1:0]  = lb.in_pix;
    for (int j = 1; j < KER_SIZE; j++) begin
      next_col[j*BW +: BW] = row_buf[j-1][col_cnt];
    end
  end
`endif

  // Row storage shifts down one buffer per accepted beat; reads see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_buf[0][col_cnt] <= lb.in_pix;
      for (int j = 1; j < NBUF; j++) begin
        row_buf[j][col_cnt] <= row_buf[j-1][col_cnt];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      clrbuffer_q <= 1'b0;
      col_data_q  <= '0;
    end else begin
      clrbuffer_q <= out_valid_q & lb.out_ready & out_last_q;
      if (in_ready) begin
        out_valid_q <= accept & emit;
        out_last_q  <= accept & row_last & col_last;
      end
      if (accept) begin
        col_data_q <= next_col;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? 16'd0 : row_cnt + 16'd1;
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  assign lb.in_ready  = in_ready;
  assign lb.out_valid = out_valid_q;
  assign lb.out_last  = out_last_q;
  assign lb.col_data  = col_data_q;
  assign lb.clrbuffer = clrbuffer_q;
  assign lb.stall     = ~(out_valid_q & lb.out_ready);
endmodule

// File: tb/tb_row_line_buffer.sv
// Bench for row_line_buffer (8-pixel rows, 4 rows, 3 taps); honours LB_TOP_PAD_EN.
module tb_row_line_buffer;
  localparam int IM_LEN = 8;
  localparam int NUP    = 4;
  localparam int ROWS   = 4;
  localparam int K      = 3;
  localparam int PIX_W  = 8;
  localparam int WORDS  = IM_LEN / NUP;
  localparam int BW     = NUP * PIX_W;
  localparam int KB     = K * BW;
`ifdef LB_TOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int OUT_PER_FRAME = PAD ? ROWS * WORDS : (ROWS - K + 1) * WORDS;

  logic clk = 1'b0;
  logic res = 1'b0;

  row_line_buffer_if #(.BW(BW), .KER_SIZE(K)) lb ();

  row_line_buffer #(
    .IM_LEN(16'(IM_LEN)), .IM_ROWS(16'(ROWS)), .KER_SIZE(K),
    .NO_PARALLEL_UNITS(NUP), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .res(res), .lb(lb)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cons_cnt = 0;

  // reference model: the frame as a 2-D image, filled in raster order
  logic [KB:0]   exp_q[$];
  logic [BW-1:0] img [ROWS][WORDS];
  int m_row = 0;
  int m_col = 0;

  function automatic logic [BW-1:0] pat(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {4{b}};
  endfunction

  function automatic logic [KB-1:0] col3(input int t2, input int t1, input int t0);
    return {pat(t2), pat(t1), pat(t0)};
  endfunction

  // scoreboard / protocol monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [KB-1:0] e;
    logic [KB:0]   got;
    logic [KB:0]   want;
    int r;
    if (res) begin
      n_tests++;
      if (lb.stall !== ~(lb.out_valid & lb.out_ready)) begin
        n_fail++;
        $display("FAIL stall_rule: got %b with out_valid=%b out_ready=%b", lb.stall, lb.out_valid, lb.out_ready);
      end
      n_tests++;
      if (lb.in_ready !== (lb.out_ready | ~lb.out_valid)) begin
        n_fail++;
        $display("FAIL ready_rule: got %b with out_valid=%b out_ready=%b", lb.in_ready, lb.out_valid, lb.out_ready);
      end
      if (lb.out_valid && lb.out_ready) begin
        cons_cnt++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: unexpected beat col_data=%h last=%b", lb.col_data, lb.out_last);
        end else begin
          want = exp_q.pop_front();
          got  = {lb.out_last, lb.col_data};
          if (got !== want) begin
            n_fail++;
            $display("FAIL scoreboard: got last=%b data=%h, expected last=%b data=%h",
                     got[KB], got[KB-1:0], want[KB], want[KB-1:0]);
          end
        end
      end
      if (lb.in_valid && lb.in_ready) begin
        e = '0;
        for (int j = 0; j < K; j++) begin
          r = m_row - j;
          if (r >= 0) e[j*BW +: BW] = (j == 0) ? lb.in_pix : img[r][m_col];
        end
        if (PAD || m_row >= K - 1)
          exp_q.push_back({(m_row == ROWS - 1) && (m_col == WORDS - 1), e});
        img[m_row][m_col] = lb.in_pix;
        if (m_col == WORDS - 1) begin
          m_col = 0;
          m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
  end

  // driver: present one beat and wait for it to be taken
  task automatic send(input logic [BW-1:0] d);
    lb.in_valid = 1'b1;
    lb.in_pix   = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lb.in_ready) begin
        @(posedge clk); #1;
        lb.in_valid = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: beat %h not accepted within 100 cycles", d);
    lb.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (lb.out_valid !== 1'b0 || lb.out_last !== 1'b0 || lb.clrbuffer !== 1'b0 ||
        lb.col_data !== '0 || lb.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got valid=%b last=%b clr=%b stall=%b data=%h, expected 0/0/0/1/0",
               tag, lb.out_valid, lb.out_last, lb.clrbuffer, lb.stall, lb.col_data);
    end
  endtask

  task automatic test_reset();
    lb.in_valid  = 1'b0;
    lb.in_pix    = '0;
    lb.out_ready = 1'b1;
    res = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    idle(2);
    res = 1'b1;
    idle(1);
  endtask

  task automatic test_stream();
    int base;
    for (int n = 0; n < 8; n++) begin
      send(pat(n));
      n_tests++;
      if (lb.out_valid !== (PAD || n >= 4)) begin
        n_fail++;
        $display("FAIL stream_valid beat %0d: got %b expected %b", n, lb.out_valid, PAD || n >= 4);
      end
      n_tests++;
      if (lb.out_last !== (n == 7)) begin
        n_fail++;
        $display("FAIL stream_last beat %0d: got %b expected %b", n, lb.out_last, n == 7);
      end
      if (n == 4 || n == 5 || n == 7 || (PAD && (n == 0 || n == 2))) begin
        logic [KB-1:0] ex;
        case (n)
          0:       ex = '0;
          2:       ex = {pat(0) & '0, pat(0) & '0, pat(2)};
          4:       ex = col3(0, 2, 4);
          5:       ex = col3(1, 3, 5);
          default: ex = col3(3, 5, 7);
        endcase
        n_tests++;
        if (lb.col_data !== ex) begin
          n_fail++;
          $display("FAIL stream_taps beat %0d: got %h expected %h", n, lb.col_data, ex);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (lb.clrbuffer !== 1'b1) begin
      n_fail++;
      $display("FAIL clrbuffer_pulse: got %b expected 1", lb.clrbuffer);
    end
    @(posedge clk); #1;
    n_tests++;
    if (lb.clrbuffer !== 1'b0) begin
      n_fail++;
      $display("FAIL clrbuffer_width: got %b expected 0", lb.clrbuffer);
    end
    // second frame must prime again
    base = cons_cnt;
    for (int n = 0; n < 8; n++) begin
      send(BW'($urandom));
      n_tests++;
      if (lb.out_valid !== (PAD || n >= 4)) begin
        n_fail++;
        $display("FAIL reprime_valid beat %0d: got %b expected %b", n, lb.out_valid, PAD || n >= 4);
      end
    end
    idle(2);
    n_tests++;
    if (cons_cnt - base !== OUT_PER_FRAME) begin
      n_fail++;
      $display("FAIL frame_count: got %0d expected %0d", cons_cnt - base, OUT_PER_FRAME);
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 5; n++) send(pat(n));
    lb.out_ready = 1'b0;
    lb.in_valid  = 1'b1;
    lb.in_pix    = pat(5);
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (lb.col_data !== col3(0, 2, 4) || lb.out_valid !== 1'b1 ||
          lb.in_ready !== 1'b0 || lb.stall !== 1'b1) begin
        n_fail++;
        $display("FAIL hold: got data=%h valid=%b in_ready=%b stall=%b, expected %h/1/0/1",
                 lb.col_data, lb.out_valid, lb.in_ready, lb.stall, col3(0, 2, 4));
      end
    end
    @(posedge clk); #1;
    lb.out_ready = 1'b1;
    for (int n = 5; n < 8; n++) send(pat(n));
    idle(3);
  endtask

  task automatic test_idle_gaps();
    int base;
    base = cons_cnt;
    for (int n = 0; n < 8; n++) begin
      send(BW'($urandom));
      idle(1);
      n_tests++;
      if (lb.stall !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_stall beat %0d: got %b expected 1", n, lb.stall);
      end
    end
    idle(2);
    n_tests++;
    if (cons_cnt - base !== OUT_PER_FRAME) begin
      n_fail++;
      $display("FAIL gap_count: got %0d expected %0d", cons_cnt - base, OUT_PER_FRAME);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 6; n++) send(pat(n + 16));
    res = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(posedge clk); #1;
    res = 1'b1;
    for (int n = 0; n < 8; n++) begin
      send(pat(n));
      n_tests++;
      if (lb.out_valid !== (PAD || n >= 4)) begin
        n_fail++;
        $display("FAIL post_reset_valid beat %0d: got %b expected %b", n, lb.out_valid, PAD || n >= 4);
      end
      if (n == 4) begin
        n_tests++;
        if (lb.col_data !== col3(0, 2, 4)) begin
          n_fail++;
          $display("FAIL post_reset_taps: got %h expected %h", lb.col_data, col3(0, 2, 4));
        end
      end
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      lb.in_valid  = ($urandom_range(0, 3) != 0);
      lb.in_pix    = BW'($urandom);
      lb.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    lb.in_valid  = 1'b0;
    lb.out_ready = 1'b1;
    idle(3);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected beats never emitted", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_idle_gaps();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
